// File: rtl/aes_decipher_iter_if.sv
// Block stream interface for the AES inverse cipher.
// Ciphertext in, plaintext out, valid/ready on both sides.
interface aes_decipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_decipher_iter.sv
// Iterative AES inverse cipher, one round per clock, AES-128/192/256.
// Round keys are expanded combinationally from the loaded key register.
module aes_decipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6,
  parameter int N  = 32 * Nk
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [N-1:0] key,
  output logic         key_ready,
  output logic         busy,
  aes_decipher_iter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_t;

  localparam int NW = 4 * (Nr + 1);
  localparam logic [3:0] NR4 = 4'(Nr);
  localparam logic [31:0] IMC = 32'h0e0b0d09;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(
    input logic [7:0] b,
    input int         n
  );
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3)
             ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]),
            sbox(t[15:8]),  sbox(t[7:0])};
  endfunction

  // fullkeys[k*128 +: 128] holds encryption round key Nr-k
  function automatic logic [128*(Nr+1)-1:0] key_expantion(
    input logic [N-1:0] k
  );
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [128*(Nr+1)-1:0] fk;
    rc = 8'h01;
    for (int i = 0; i < Nk; i++)
      w[i] = k[N-1-32*i -: 32];
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
    for (int r = 0; r <= Nr; r++)
      fk[128*r +: 128] = {w[4*(Nr-r)],   w[4*(Nr-r)+1],
                          w[4*(Nr-r)+2], w[4*(Nr-r)+3]};
    return fk;
  endfunction

  function automatic logic [127:0] inverse_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    int src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      src = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
      o[127-8*i -: 8] = s[127-8*src -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_byte(
    input logic [127:0] s
  );
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = isbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0] acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-8*(4*c+j) -: 8],
                           IMC[31-8*((j-r+4)%4) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  state_t state, state_n;
  logic [N-1:0]  key_q;
  logic          key_loaded;
  logic [127:0]  st;
  logic [3:0]    rnd;
  logic [127:0]  out_q;
  logic          out_v;
  logic [128*(Nr+1)-1:0] fullkeys;
  logic [127:0]  rk [16];
  logic [127:0]  rk_cur, isb, round_out;
  logic          accept;

  always_comb begin
    fullkeys = key_expantion(key_q);
    for (int k = 0; k < 16; k++) rk[k] = '0;
    for (int k = 0; k <= Nr; k++)
      rk[k] = fullkeys[128*k +: 128];
  end

  assign rk_cur    = rk[rnd];
  assign isb       = inv_sub_byte(inverse_shift_rows(st));
  assign round_out = inv_mix_columns(isb ^ rk_cur);

  assign key_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign bus.in_ready = (state == S_IDLE) && key_loaded && !key_load;
  assign bus.out_valid = out_v;
  assign bus.out_data  = out_q;
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_ROUND;
      S_ROUND: if (rnd == NR4) state_n = S_DONE;
      S_DONE:  if (out_v && bus.out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= '0;
      key_loaded <= 1'b0;
      st         <= '0;
      rnd        <= '0;
      out_q      <= '0;
      out_v      <= 1'b0;
    end else begin
      if (key_load && key_ready) begin
        key_q      <= key;
        key_loaded <= 1'b1;
      end
      unique case (state)
        S_IDLE: if (accept) begin
          st  <= bus.in_data ^ rk[0];
          rnd <= 4'd1;
        end
        S_ROUND: if (rnd < NR4) begin
          st  <= round_out;
          rnd <= rnd + 4'd1;
        end else begin
          out_q <= isb ^ rk_cur;
          out_v <= 1'b1;
        end
        S_DONE: if (out_v && bus.out_ready) out_v <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decipher_iter.sv
// Bench for aes_decipher_iter: FIPS-197 vectors plus random blocks
// produced by a forward-cipher model, for Nk = 4, 6 and 8.
module tb_aes_decipher_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]   kl, iv, ordy;
  logic [255:0] kv [3];
  logic [127:0] idata [3];
  wire  [2:0]   kr, bz, ir, ov;
  wire  [127:0] odata [3];

  logic [7:0] sbox [256];
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  aes_decipher_iter_if bi [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bi[g].in_valid  = iv[g];
    assign bi[g].in_data   = idata[g];
    assign bi[g].out_ready = ordy[g];
    assign ir[g]    = bi[g].in_ready;
    assign ov[g]    = bi[g].out_valid;
    assign odata[g] = bi[g].out_data;
  end

  aes_decipher_iter #(.Nk(4)) dut4 (
    .clk(clk), .rst(rst), .key_load(kl[0]),
    .key(kv[0][255:128]), .key_ready(kr[0]),
    .busy(bz[0]), .bus(bi[0])
  );
  aes_decipher_iter #(.Nk(6)) dut6 (
    .clk(clk), .rst(rst), .key_load(kl[1]),
    .key(kv[1][255:64]), .key_ready(kr[1]),
    .busy(bz[1]), .bus(bi[1])
  );
  aes_decipher_iter #(.Nk(8)) dut8 (
    .clk(clk), .rst(rst), .key_load(kl[2]),
    .key(kv[2]), .key_ready(kr[2]),
    .busy(bz[2]), .bus(bi[2])
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box by walking the generator 3 and its inverse
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  // Forward cipher; the DUT must invert it
  function automatic logic [127:0] aes_enc(
    input logic [255:0] k,
    input int           nk,
    input logic [127:0] pt
  );
    logic [7:0] w [240];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] a [4];
    logic [7:0] rc, t0;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4*nk; i++) w[i] = k[255-8*i -: 8];
    for (int i = nk; i < 4*(nr+1); i++) begin
      for (int b = 0; b < 4; b++) tmp[b] = w[4*(i-1)+b];
      if (i % nk == 0) begin
        t0 = tmp[0];
        tmp[0] = sbox[tmp[1]] ^ rc;
        tmp[1] = sbox[tmp[2]];
        tmp[2] = sbox[tmp[3]];
        tmp[3] = sbox[t0];
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        for (int b = 0; b < 4; b++) tmp[b] = sbox[tmp[b]];
      end
      for (int b = 0; b < 4; b++)
        w[4*i+b] = w[4*(i-nk)+b] ^ tmp[b];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int i = 0; i < 16; i++)
        s[i] = t[(i%4) + 4*(((i/4) + (i%4)) % 4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          s[4*c]   = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
          s[4*c+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
          s[4*c+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
          s[4*c+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic load_key(input int d, input logic [255:0] k);
    @(negedge clk);
    chk("key_ready", 128'(kr[d]), 128'd1);
    kl[d] = 1'b1;
    kv[d] = k;
    @(negedge clk);
    kl[d] = 1'b0;
  endtask

  // Edge count includes the accept edge itself
  task automatic send(input int d, input logic [127:0] ct,
                      input logic [127:0] exp, input int hold,
                      input bit bad_key);
    int edges;
    int nr;
    logic [255:0] good;
    nr = 10 + 2*d;
    good = kv[d];
    ordy[d] = (hold == 0);
    @(negedge clk);
    iv[d] = 1'b1;
    idata[d] = ct;
    chk("in_ready_idle", 128'(ir[d]), 128'd1);
    @(posedge clk);
    #1 iv[d] = 1'b0;
    edges = 1;
    while (!ov[d] && edges < 40) begin
      chk("busy_round", 128'(bz[d]), 128'd1);
      chk("in_ready_round", 128'(ir[d]), 128'd0);
      if (bad_key && edges == 3) begin
        chk("key_ready_round", 128'(kr[d]), 128'd0);
        kl[d] = 1'b1;
        kv[d] = ~good;
      end
      if (bad_key && edges == 4) begin
        kl[d] = 1'b0;
        kv[d] = good;
      end
      @(posedge clk);
      #1 edges++;
    end
    chk("latency", 128'(edges), 128'(nr + 1));
    chk("out_data", odata[d], exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_data", odata[d], exp);
      chk("hold_valid", 128'(ov[d]), 128'd1);
      chk("hold_in_ready", 128'(ir[d]), 128'd0);
    end
    if (hold > 0) begin
      @(negedge clk);
      ordy[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("post_hs_valid", 128'(ov[d]), 128'd0);
    chk("post_hs_in_ready", 128'(ir[d]), 128'd1);
    chk("post_hs_busy", 128'(bz[d]), 128'd0);
    chk("post_hs_data", odata[d], exp);
  endtask

  logic [255:0] fk [3];
  logic [127:0] fct [3];
  logic [255:0] rkey;
  logic [127:0] rpt, rct;

  initial begin
    build_sbox();
    fk[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    fk[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
             64'h0};
    fk[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    fct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    fct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    fct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    rst = 1'b1;
    kl = '0;
    iv = '0;
    ordy = '1;
    for (int d = 0; d < 3; d++) begin
      kv[d] = '0;
      idata[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", 128'(ov[d]), 128'd0);
      chk("rst_out_data", odata[d], 128'd0);
      chk("rst_busy", 128'(bz[d]), 128'd0);
      chk("rst_in_ready", 128'(ir[d]), 128'd0);
      chk("rst_key_ready", 128'(kr[d]), 128'd1);
    end

    // data offered before any key is never taken
    iv = '1;
    repeat (8) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk("nokey_in_ready", 128'(ir[d]), 128'd0);
        chk("nokey_busy", 128'(bz[d]), 128'd0);
      end
    end
    iv = '0;

    for (int d = 0; d < 3; d++) begin
      load_key(d, fk[d]);
      send(d, fct[d], PT, 0, 1'b0);
    end

    send(0, fct[0], PT, 20, 1'b0);
    send(0, fct[0], PT, 0, 1'b0);
    send(0, fct[0], PT, 0, 1'b1);

    // key_load and in_valid together: key first, data next cycle
    rkey = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    rpt = {$urandom, $urandom, $urandom, $urandom};
    rct = aes_enc(rkey, 4, rpt);
    @(negedge clk);
    kl[0] = 1'b1;
    kv[0] = rkey;
    iv[0] = 1'b1;
    idata[0] = rct;
    #1;
    chk("same_cycle_in_ready", 128'(ir[0]), 128'd0);
    chk("same_cycle_key_ready", 128'(kr[0]), 128'd1);
    @(posedge clk);
    #1 kl[0] = 1'b0;
    send(0, rct, rpt, 0, 1'b0);

    for (int d = 0; d < 3; d++)
      for (int j = 0; j < 4; j++) begin
        if (j % 2 == 0) begin
          rkey = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
          if (d == 0) rkey[127:0] = '0;
          if (d == 1) rkey[63:0] = '0;
          load_key(d, rkey);
        end
        rpt = {$urandom, $urandom, $urandom, $urandom};
        rct = aes_enc(rkey, 4 + 2*d, rpt);
        send(d, rct, rpt, (j == 3) ? 3 : 0, 1'b0);
      end

    // reset in the middle of a block at rnd = 5
    load_key(0, fk[0]);
    @(negedge clk);
    iv[0] = 1'b1;
    idata[0] = fct[0];
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", 128'(ov[0]), 128'd0);
    chk("midrst_out_data", odata[0], 128'd0);
    chk("midrst_in_ready", 128'(ir[0]), 128'd0);
    chk("midrst_busy", 128'(bz[0]), 128'd0);
    chk("midrst_key_ready", 128'(kr[0]), 128'd1);
    load_key(0, fk[0]);
    send(0, fct[0], PT, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
